// File: rtl/ram4bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram4bank_pkg
// Description : Shared defaults and state encoding for the four-bank RAM
//               reader (ram4bank_reader and its output buffer).
// Revision    : 1.0 - initial release
// ============================================================================
package ram4bank_pkg;

  localparam int c_addr_w = 13;  // bank address width
  localparam int c_data_w = 8;   // per-bank data width
  localparam int c_rd_lat = 1;   // bank read latency, enb/AB to DB valid

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buf
// Description : Small valid/ready FIFO with fall-through. When empty, an
//               arriving word is presented directly on the master side; if it
//               is not taken it is stored, so the presented data never changes
//               until accepted.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_s_valid/i_s_data/o_s_ready - slave (write) side
//               o_m_valid/o_m_data/i_m_ready - master (read) side
//               o_count           - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_s_valid,
  input  logic [WIDTH-1:0]           i_s_data,
  output logic                       o_s_ready,
  output logic                       o_m_valid,
  output logic [WIDTH-1:0]           o_m_data,
  input  logic                       i_m_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty   = (r_count == '0);
  assign o_m_valid = !w_empty || i_s_valid;
  // Zero when nothing is presented so the output is clean out of reset.
  assign o_m_data  = !w_empty ? r_mem[r_rd] : (i_s_valid ? i_s_data : '0);
  assign w_pop     = !w_empty && i_m_ready;
  // A word arriving into an empty buffer that is taken at once is never stored.
  assign w_push    = i_s_valid && !(w_empty && i_m_ready);
  assign o_s_ready = (r_count < CNT_W'(DEPTH)) || i_m_ready;
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_s_data;
        r_wr        <= f_next(r_wr);
      end
      if (w_pop) r_rd <= f_next(r_rd);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram4bank_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram4bank_reader
// Description : Reads a run of consecutive addresses from four parallel RAM
//               banks and streams {DB4,DB3,DB2,DB1} out on a valid/ready port.
//               Reads are issued only while the buffered plus in-flight words
//               fit in the RD_LAT+1 entry output buffer.
// Ports       : clk, rst_n                - clock, async active-low reset
//               start, base_addr, length  - job launch (sampled on start)
//               busy, done                - job status
//               rstb_busy, enb, rstb      - bank read-port control
//               AB1..AB4, DB1..DB4        - bank addresses / read data
//               m_tdata/m_tvalid/m_tready/m_tlast - output stream
// Revision    : 1.0 - initial release
// ============================================================================
module ram4bank_reader
  import ram4bank_pkg::*;
#(
  parameter int ADDR_W = c_addr_w,
  parameter int DATA_W = c_data_w,
  parameter int RD_LAT = c_rd_lat
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  input  logic                rstb_busy,
  output logic                enb,
  output logic                rstb,
  output logic [ADDR_W-1:0]   AB1,
  output logic [ADDR_W-1:0]   AB2,
  output logic [ADDR_W-1:0]   AB3,
  output logic [ADDR_W-1:0]   AB4,
  input  logic [DATA_W-1:0]   DB1,
  input  logic [DATA_W-1:0]   DB2,
  input  logic [DATA_W-1:0]   DB3,
  input  logic [DATA_W-1:0]   DB4,
  output logic [4*DATA_W-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(2 * RD_LAT + 2) + 1;
  localparam int LEN_W = ADDR_W + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_remain;
  logic [RD_LAT-1:0]   r_pipe_vld;   // one bit per read still inside the bank
  logic [RD_LAT-1:0]   r_pipe_last;
  logic                r_done;
  logic                w_issue;
  logic                w_pop;
  logic                w_last_hs;
  logic                w_buf_ready;
  logic [CNT_W-1:0]    w_count;
  logic [SUM_W-1:0]    w_inflight;
  logic [SUM_W-1:0]    w_used;
  logic [4*DATA_W:0]   w_s_data;
  logic [4*DATA_W:0]   w_m_data;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + SUM_W'(r_pipe_vld[i]);
  end

  // A slot freed by this cycle's handshake may be reused by this cycle's
  // issue, which is what allows one word per cycle with m_tready held high.
  assign w_used    = SUM_W'(w_count) + w_inflight - SUM_W'(w_pop);
  // w_buf_ready always holds when the occupancy test passes; it guards
  // against overrunning the buffer should the two ever disagree.
  assign w_issue   = (r_state == S_RUN) && !rstb_busy && (r_remain != '0) &&
                     (w_used < SUM_W'(DEPTH)) && w_buf_ready;
  assign w_pop     = m_tvalid && m_tready;
  assign w_last_hs = w_pop && m_tlast;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_remain == '0)  w_state_nxt = S_IDLE;
        else if (!rstb_busy) w_state_nxt = S_RUN;
      end
      S_RUN:   if (w_issue && (r_remain == LEN_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= ((r_state == S_WAIT) && (r_remain == '0)) ||
                 ((r_state == S_DRAIN) && w_last_hs);
      if ((r_state == S_IDLE) && start) begin
        r_addr   <= base_addr;
        r_remain <= length;
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - LEN_W'(1);
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue && (r_remain == LEN_W'(1));
    end
  end

  // The oldest pipe stage marks the cycle in which DB carries its word.
  assign w_s_data = {r_pipe_last[RD_LAT-1], DB4, DB3, DB2, DB1};

  stream_skid_buf #(
    .DEPTH (DEPTH),
    .WIDTH (4 * DATA_W + 1)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_s_valid (r_pipe_vld[RD_LAT-1]),
    .i_s_data  (w_s_data),
    .o_s_ready (w_buf_ready),
    .o_m_valid (m_tvalid),
    .o_m_data  (w_m_data),
    .i_m_ready (m_tready),
    .o_count   (w_count)
  );

  assign m_tdata = w_m_data[4*DATA_W-1:0];
  assign m_tlast = w_m_data[4*DATA_W];
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign enb     = w_issue;
  assign rstb    = 1'b0;
  assign AB1     = r_addr;
  assign AB2     = r_addr;
  assign AB3     = r_addr;
  assign AB4     = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram4bank_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram4bank_reader
// Description : Self-checking bench for ram4bank_reader. Banks are modelled
//               with bankN[a] = N*16 + a; expected addresses and words are
//               queued at job launch and compared as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram4bank_reader;

  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, enb, rstb;
  logic          rstb_busy = 1'b0;
  logic [AW-1:0] AB1, AB2, AB3, AB4;
  logic [DW-1:0] DB1, DB2, DB3, DB4;
  logic [4*DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;

  ram4bank_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .rstb_busy(rstb_busy),
    .enb(enb), .rstb(rstb), .AB1(AB1), .AB2(AB2), .AB3(AB3), .AB4(AB4),
    .DB1(DB1), .DB2(DB2), .DB3(DB3), .DB4(DB4), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int hs_cnt = 0, enb_cnt = 0, outst = 0;
  int first_vld = -1, last_hs = -1;
  bit rand_ready = 1'b0;
  logic [AW-1:0] ab_q[$];
  logic [4*DW:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bank model: registered read, one cycle latency.
  logic [DW-1:0] bank [4][1<<AW];
  initial for (int n = 0; n < 4; n++) for (int a = 0; a < (1<<AW); a++) bank[n][a] = 8'((n+1)*16 + a);
  always @(posedge clk) if (enb) begin
    DB1 <= bank[0][AB1]; DB2 <= bank[1][AB2]; DB3 <= bank[2][AB3]; DB4 <= bank[3][AB4];
  end

  function automatic logic [4*DW-1:0] word_of(input logic [AW-1:0] a);
    logic [7:0] lo = a[7:0];
    return {8'h40 + lo, 8'h30 + lo, 8'h20 + lo, 8'h10 + lo};
  endfunction

  initial forever begin
    @(posedge clk); #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor / scoreboard, sampling on the falling edge.
  logic          held_v = 1'b0;
  logic [4*DW:0] held_w, mon_w;
  logic [AW-1:0] mon_a;
  int            hs_now;
  always @(negedge clk) begin
    if (rst_n) begin
      if (held_v) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", {m_tlast, m_tdata}, held_w);
      end
      hs_now = (m_tvalid && m_tready) ? 1 : 0;
      if (enb) begin
        check("outstanding_le_lat1", (outst + 1 - hs_now) <= LAT + 1, 1);
        if (ab_q.size() == 0) check("enb_unexpected", enb, 0);
        else begin
          mon_a = ab_q.pop_front();
          check("AB", {AB1, AB2, AB3, AB4}, {mon_a, mon_a, mon_a, mon_a});
        end
        enb_cnt++;
      end
      if (m_tvalid && first_vld < 0) first_vld = cyc;
      if (hs_now == 1) begin
        if (exp_q.size() == 0) check("word_unexpected", m_tvalid, 0);
        else begin
          mon_w = exp_q.pop_front();
          check("word", {m_tlast, m_tdata}, mon_w);
        end
        hs_cnt++;
        if (m_tlast) last_hs = cyc;
      end
      outst  = outst + (enb ? 1 : 0) - hs_now;
      held_v = m_tvalid && !m_tready;
      held_w = {m_tlast, m_tdata};
    end else begin
      held_v = 1'b0;
      outst  = 0;
    end
  end

  task automatic push_exp(input logic [AW-1:0] base, input logic [AW:0] len);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + AW'(i);
      ab_q.push_back(a);
      exp_q.push_back({(i == int'(len) - 1), word_of(a)});
    end
  endtask

  // Caller drives at the desired moment; start is sampled on the next edge.
  task automatic launch(input logic [AW-1:0] base, input logic [AW:0] len, output int s);
    push_exp(base, len);
    start = 1'b1; base_addr = base; length = len;
    first_vld = -1; last_hs = -1;
    s = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    int n = 0;
    dcyc = -1;
    while (n < 500) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; break; end
      n++;
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  // Timing is counted from the edge that samples start: first m_tvalid
  // RD_LAT+1 edges later, and done one edge after the sampled event.
  task automatic run_job(input logic [AW-1:0] base, input logic [AW:0] len, input int hold);
    int s, d, e0;
    @(posedge clk); #1;
    e0 = enb_cnt;
    rstb_busy = (hold > 0);
    launch(base, len, s);
    for (int k = 0; k < hold; k++) begin
      if (k == 3) begin start = 1'b1; base_addr = 13'd999; length = 14'd2; end
      if (k == 4) start = 1'b0;
      @(negedge clk); check("enb_while_rstb_busy", enb, 0);
      @(posedge clk); #1;
    end
    rstb_busy = 1'b0;
    wait_done(d);
    if (len == 0) begin
      check("done_lat_len0", d - s, 1);
      check("no_enb_len0", enb_cnt - e0, 0);
    end else begin
      check("done_after_last", d - last_hs, 1);
      if (hold == 0) check("first_valid_lat", first_vld - s, LAT + 1);
      if (!rand_ready) check("one_word_per_cycle", last_hs - first_vld, int'(len) - 1);
    end
    check("busy_at_done", busy, 0);
    check("scoreboard_empty", exp_q.size() + ab_q.size(), 0);
  endtask

  int s_job, d_job, h0, n;
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enb_rstb", {enb, rstb}, 0);
    check("rst_ab", {AB1, AB2, AB3, AB4}, 0);
    check("rst_stream", {m_tvalid, m_tlast, m_tdata}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(13'd0, 14'd4, 0);        // 0x40302010 .. 0x43332313
    run_job(13'd8190, 14'd4, 0);     // AB 8190, 8191, 0, 1
    rand_ready = 1'b1;
    run_job(13'd100, 14'd16, 0);
    rand_ready = 1'b0;
    run_job(13'd5, 14'd0, 0);
    run_job(13'd20, 14'd6, 10);

    // Start in the same cycle as done.
    run_job(13'd40, 14'd3, 0);
    launch(13'd60, 14'd5, s_job);
    check("b2b_accepted", busy, 1);
    check("done_single_cycle", done, 0);
    wait_done(d_job);
    check("b2b_done", d_job - last_hs, 1);
    check("b2b_empty", exp_q.size() + ab_q.size(), 0);

    // Abort at word 3 of 8, then restart right after reset release.
    @(posedge clk); #1;
    h0 = hs_cnt;
    launch(13'd300, 14'd8, s_job);
    n = 0;
    while (hs_cnt - h0 < 3 && n < 100) begin @(posedge clk); #2; n++; end
    check("reached_word3", hs_cnt - h0, 3);
    rst_n = 1'b0;
    #1;
    check("abort_busy_done", {busy, done}, 0);
    check("abort_enb", enb, 0);
    check("abort_ab", {AB1, AB2, AB3, AB4}, 0);
    check("abort_stream", {m_tvalid, m_tlast, m_tdata}, 0);
    exp_q.delete(); ab_q.delete();
    repeat (3) begin @(negedge clk); check("no_done_in_reset", done, 0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    launch(13'd50, 14'd5, s_job);
    wait_done(d_job);
    check("restart_first_valid", first_vld - s_job, LAT + 1);
    check("restart_done", d_job - last_hs, 1);
    check("restart_empty", exp_q.size() + ab_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ram4bank_reader.md
RAM4BANK_READER -- requirements
Module: ram4bank_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning the bank address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the per-bank data width.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning the bank read latency in cycles from enb/AB to DB valid.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that launches a read job.
REQ-007 SHALL have port base_addr, input, ADDR_W, the first read address, sampled on start.
REQ-008 SHALL have port length, input, ADDR_W+1, the word count, sampled on start, with legal values 0..2^ADDR_W.
REQ-009 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse at job end.
REQ-011 SHALL have port rstb_busy, input, 1, the bank read-port reset-busy flag.
REQ-012 SHALL have port enb, output, 1, the bank read enable, common to all four banks.
REQ-013 SHALL have port rstb, output, 1, the bank read-port reset, driven constant 0.
REQ-014 SHALL have ports AB1..AB4, output, ADDR_W each, the bank read addresses, all driven with the same value.
REQ-015 SHALL have ports DB1..DB4, input, DATA_W each, the bank read data.
REQ-016 SHALL have port m_tdata, output, 4*DATA_W, the output word {DB4,DB3,DB2,DB1}.
REQ-017 SHALL have ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1), the output stream handshake and the last-word marker.

Function
REQ-018 SHALL implement states IDLE, WAIT, RUN and DRAIN.
- IDLE -> WAIT on start.
- WAIT -> RUN when rstb_busy=0.
- RUN -> DRAIN when the last read is issued.
- DRAIN -> IDLE when the last word is accepted (m_tvalid & m_tready & m_tlast).
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL, for length=0, pulse done exactly 1 cycle after start, with no enb and no m_tvalid.
REQ-021 SHALL assert enb for exactly one cycle per issued read, only in RUN, and only when (buffer occupancy + reads in flight) < RD_LAT+1.
REQ-022 SHALL increment the read address by 1 per issued read, modulo 2^ADDR_W (8191 -> 0 wraps).
REQ-023 SHALL capture DB1..DB4 into an output buffer of RD_LAT+1 entries exactly RD_LAT cycles after the corresponding enb.
REQ-024 SHALL never drop or duplicate a word under any m_tready pattern.
REQ-025 SHALL present the buffer head on m_tdata while m_tvalid=1, holding m_tdata stable until accepted.
REQ-026 SHALL NOT depend on m_tready combinationally for m_tvalid.
REQ-027 SHALL assert m_tlast only with the length-th word of the job.
REQ-028 SHALL, with m_tready held at 1 and rstb_busy=0, sustain 1 word per cycle, with the first m_tvalid RD_LAT+1 cycles after start.
REQ-029 SHALL assert done in the cycle after the last-word handshake and return busy to 0 in that same cycle.
REQ-030 SHALL allow a start in the same cycle as done to be accepted.
REQ-031 SHALL, if rstb_busy rises during RUN, suppress new issues until it falls; in-flight words SHALL still be captured.

Reset
REQ-032 SHALL, with rst_n=0, immediately (asynchronously) force: state=IDLE, busy=0, done=0, enb=0, AB1..AB4=0, m_tvalid=0, m_tlast=0, m_tdata=0, and buffer and counters cleared.
REQ-033 SHALL abort any job when reset is asserted mid-job, with no done pulse.
REQ-034 SHALL accept start on the first clk edge after rst_n deasserts.

Structure
REQ-035 SHALL place ADDR_W, DATA_W, RD_LAT defaults and the state encoding in a shared package, ram4bank_pkg.
REQ-036 SHALL implement the output buffer as one sub-module, stream_skid_buf (parameterised depth and width, valid/ready on both sides).

Verification
REQ-037 SHALL verify: base_addr=0, length=4, m_tready=1, banks preloaded with bankN[a]=N*16+a -> m_tdata 0x40302010, 0x41312111, 0x42322212, 0x43332313, m_tlast on the 4th word, done 1 cycle later.
REQ-038 SHALL verify: base_addr=8190, length=4 -> AB sequence 8190, 8191, 0, 1.
REQ-039 SHALL verify: length=16, m_tready random at 50% -> all 16 words in order and intact, never more than 2 reads outstanding beyond the buffer.
REQ-040 SHALL verify: length=0 -> done pulse 1 cycle after start, enb never high.
REQ-041 SHALL verify: rstb_busy=1 for 10 cycles after start -> enb stays 0 for those 10 cycles, then the normal stream follows.
REQ-042 SHALL verify: rst_n pulsed low at word 3 of 8, then a new start -> outputs reset immediately, no done for the aborted job, the new job completes correctly.
